// File: rtl/sinc_pkg.sv
// Shared definitions for the multi-lane 8b/10b receive synchroniser:
// one-hot sync states, comma/idle patterns and the accepted code-group table.
package sinc_pkg;

    // One-hot synchronisation states
    typedef enum logic [4:0] {
        ST_LOSS_OF_SYNC = 5'b00001,
        ST_COMMA_DETECT = 5'b00010,
        ST_ACQUIRE_SYNC = 5'b00100,
        ST_SYNC_OK      = 5'b01000,
        ST_SYNC_BAD     = 5'b10000
    } sinc_state_e;

    // Comma patterns on cg[9:3] (bit 9 is the first received bit)
    localparam logic [6:0] COMMA_PLUS  = 7'b1100000;
    localparam logic [6:0] COMMA_MINUS = 7'b0011111;

    // Idle data code-groups that complete a comma/idle pair
    localparam logic [9:0] IDLE_D5_6  = 10'b1010010110;
    localparam logic [9:0] IDLE_D16_2 = 10'b1001000101;

    localparam int CG_TABLE_SIZE = 28;

    // Accepted code-groups: D0.0..D9.0 (both disparities), D5.6, D16.2,
    // K28.5, K27.7 and K29.7 (both disparities)
    localparam logic [CG_TABLE_SIZE-1:0][9:0] CG_TABLE = {
        10'b1001110100, 10'b0110001011,   // D0.0  -/+
        10'b0111010100, 10'b1000101011,   // D1.0  -/+
        10'b1011010100, 10'b0100101011,   // D2.0  -/+
        10'b1100011011, 10'b1100010100,   // D3.0  -/+
        10'b1101010100, 10'b0010101011,   // D4.0  -/+
        10'b1010011011, 10'b1010010100,   // D5.0  -/+
        10'b0110011011, 10'b0110010100,   // D6.0  -/+
        10'b1110001011, 10'b0001110100,   // D7.0  -/+
        10'b1110010100, 10'b0001101011,   // D8.0  -/+
        10'b1001011011, 10'b1001010100,   // D9.0  -/+
        10'b1010010110,                   // D5.6
        10'b1001000101,                   // D16.2
        10'b0011111010, 10'b1100000101,   // K28.5 -/+
        10'b1101101000, 10'b0010010111,   // K27.7 -/+
        10'b1011101000, 10'b0100010111    // K29.7 -/+
    };

    // Membership test against the accepted code-group table
    function automatic logic cg_valid(input logic [9:0] cg);
        logic hit_s;
        hit_s = 1'b0;
        for (int i = 0; i < CG_TABLE_SIZE; i++) begin
            if (CG_TABLE[i] == cg) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/sinc_cg_clasificador.sv
// Combinational per-lane classifier: flags a 10-bit code-group as valid,
// comma and/or idle. Slot parity is applied by the lane FSM, not here.
module sinc_cg_clasificador
    import sinc_pkg::*;
#(
    parameter bit COMMA_BOTH = 1'b1
) (
    input  logic [9:0] cg,
    output logic       valid,
    output logic       comma,
    output logic       idle
);

    // Decode table membership, comma and idle for the incoming group
    always_comb begin
        valid = cg_valid(cg);
        idle  = (cg == IDLE_D5_6) || (cg == IDLE_D16_2);
        if (COMMA_BOTH) begin
            comma = (cg[9:3] == COMMA_PLUS) || (cg[9:3] == COMMA_MINUS);
        end else begin
            comma = (cg[9:3] == COMMA_PLUS);
        end
    end

endmodule

// File: rtl/sincronizador_multicanal.sv
// N-lane 8b/10b receive synchroniser. Each lane runs its own sync FSM with
// even/odd slot tracking; every status output is registered and aligned with
// the one-cycle-delayed code-group on rx_code_group_out.
module sincronizador_multicanal
    import sinc_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int ACQ_COMMAS  = 3,
    parameter int GOOD_CGS    = 4,
    parameter int LOSS_LEVELS = 3,
    parameter bit COMMA_BOTH  = 1'b1
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic [10*NUM_LANES-1:0] rx_code_group,
    input  logic [NUM_LANES-1:0]    lane_enable,
    output logic [10*NUM_LANES-1:0] rx_code_group_out,
    output logic [NUM_LANES-1:0]    code_status,
    output logic [NUM_LANES-1:0]    rx_even,
    output logic [NUM_LANES-1:0]    cg_invalid,
    output logic                    all_sync
);

    localparam int CC_W = $clog2(ACQ_COMMAS + 1);
    localparam int BL_W = $clog2(LOSS_LEVELS + 1);
    localparam int GC_W = $clog2(GOOD_CGS + 1);

    localparam logic [CC_W-1:0] CC_MAX  = CC_W'(ACQ_COMMAS);
    localparam logic [CC_W-1:0] CC_ONE  = CC_W'(1'b1);
    localparam logic [BL_W-1:0] BL_MAX  = BL_W'(LOSS_LEVELS);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1'b1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GOOD_CGS - 1);
    localparam logic [GC_W-1:0] GC_ONE  = GC_W'(1'b1);

    logic [NUM_LANES-1:0] cs_next_s;
    logic                 all_sync_r;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [9:0]      cg_s;
        logic            valid_s;
        logic            comma_s;
        logic            idle_s;
        logic            even_slot_s;
        logic            cgbad_s;
        sinc_state_e     state_r;
        sinc_state_e     state_n;
        logic [CC_W-1:0] comma_cnt_r;
        logic [CC_W-1:0] comma_cnt_n;
        logic [BL_W-1:0] bad_lvl_r;
        logic [BL_W-1:0] bad_lvl_n;
        logic [GC_W-1:0] good_cnt_r;
        logic [GC_W-1:0] good_cnt_n;
        logic            even_r;
        logic            cs_r;
        logic            cg_inv_r;
        logic [9:0]      cg_q_r;

        assign cg_s = rx_code_group[10*i +: 10];

        sinc_cg_clasificador #(
            .COMMA_BOTH (COMMA_BOTH)
        ) u_clasificador (
            .cg    (cg_s),
            .valid (valid_s),
            .comma (comma_s),
            .idle  (idle_s)
        );

        // Slot parity, cgbad qualification and next-state/counter logic
        always_comb begin
            state_n     = state_r;
            comma_cnt_n = comma_cnt_r;
            bad_lvl_n   = bad_lvl_r;
            good_cnt_n  = good_cnt_r;

            // A comma seen while out of sync defines the even slot
            if ((state_r == ST_LOSS_OF_SYNC) && comma_s) begin
                even_slot_s = 1'b1;
            end else begin
                even_slot_s = ~even_r;
            end
            cgbad_s = ~valid_s | (comma_s & ~even_slot_s);

            case (state_r)
                ST_LOSS_OF_SYNC: begin
                    if (comma_s) begin
                        state_n     = ST_COMMA_DETECT;
                        comma_cnt_n = CC_ONE;
                    end else begin
                        comma_cnt_n = '0;
                        bad_lvl_n   = '0;
                        good_cnt_n  = '0;
                    end
                end
                ST_COMMA_DETECT: begin
                    if (idle_s && (comma_cnt_r == CC_MAX)) begin
                        state_n = ST_SYNC_OK;
                    end else if (idle_s) begin
                        state_n = ST_ACQUIRE_SYNC;
                    end else begin
                        state_n = ST_LOSS_OF_SYNC;
                    end
                end
                ST_ACQUIRE_SYNC: begin
                    if (cgbad_s) begin
                        state_n = ST_LOSS_OF_SYNC;
                    end else if (comma_s) begin
                        state_n = ST_COMMA_DETECT;
                        if (comma_cnt_r != CC_MAX) begin
                            comma_cnt_n = comma_cnt_r + CC_ONE;
                        end else begin
                            comma_cnt_n = comma_cnt_r;
                        end
                    end else begin
                        state_n = ST_ACQUIRE_SYNC;
                    end
                end
                ST_SYNC_OK: begin
                    if (cgbad_s) begin
                        state_n    = ST_SYNC_BAD;
                        bad_lvl_n  = BL_ONE;
                        good_cnt_n = '0;
                    end else begin
                        state_n = ST_SYNC_OK;
                    end
                end
                ST_SYNC_BAD: begin
                    if (cgbad_s) begin
                        good_cnt_n = '0;
                        if (bad_lvl_r == BL_MAX) begin
                            state_n   = ST_LOSS_OF_SYNC;
                            bad_lvl_n = '0;
                        end else begin
                            bad_lvl_n = bad_lvl_r + BL_ONE;
                        end
                    end else if (good_cnt_r == GC_LAST) begin
                        // A full run of good groups lowers the bad level by one
                        good_cnt_n = '0;
                        bad_lvl_n  = bad_lvl_r - BL_ONE;
                        if (bad_lvl_r == BL_ONE) begin
                            state_n = ST_SYNC_OK;
                        end else begin
                            state_n = ST_SYNC_BAD;
                        end
                    end else begin
                        good_cnt_n = good_cnt_r + GC_ONE;
                    end
                end
                default: begin
                    state_n     = ST_LOSS_OF_SYNC;
                    comma_cnt_n = '0;
                    bad_lvl_n   = '0;
                    good_cnt_n  = '0;
                end
            endcase
        end

        assign cs_next_s[i] = (state_n == ST_SYNC_OK) || (state_n == ST_SYNC_BAD);

        // Lane state, counters and registered status; disabled lanes sit in reset
        always_ff @(posedge clk) begin
            if (RESET || !lane_enable[i]) begin
                state_r     <= ST_LOSS_OF_SYNC;
                comma_cnt_r <= '0;
                bad_lvl_r   <= '0;
                good_cnt_r  <= '0;
                even_r      <= 1'b0;
                cs_r        <= 1'b0;
                cg_inv_r    <= 1'b0;
                cg_q_r      <= '0;
            end else begin
                state_r     <= state_n;
                comma_cnt_r <= comma_cnt_n;
                bad_lvl_r   <= bad_lvl_n;
                good_cnt_r  <= good_cnt_n;
                even_r      <= even_slot_s;
                cs_r        <= cs_next_s[i];
                cg_inv_r    <= cgbad_s;
                cg_q_r      <= cg_s;
            end
        end

        assign rx_code_group_out[10*i +: 10] = cg_q_r;
        assign code_status[i]                = cs_r;
        assign rx_even[i]                    = even_r;
        assign cg_invalid[i]                 = cg_inv_r;
    end

    // Aggregate sync flag over enabled lanes, aligned with code_status
    always_ff @(posedge clk) begin
        if (RESET) begin
            all_sync_r <= 1'b0;
        end else begin
            all_sync_r <= (|lane_enable) & (&(cs_next_s | ~lane_enable));
        end
    end

    assign all_sync = all_sync_r;

endmodule

// File: tb/tb_sincronizador_multicanal.sv
// Self-checking bench for sincronizador_multicanal: a behavioural reference
// model pushes expected outputs per driven cycle into a scoreboard queue, and
// each scenario task adds its own direct checks on key moments.
module tb_sincronizador_multicanal;

    localparam int N     = 4;
    localparam int ACQ   = 3;
    localparam int GOOD  = 4;
    localparam int LOSSL = 3;

    localparam int S_LOS = 0;
    localparam int S_CD  = 1;
    localparam int S_ACQ = 2;
    localparam int S_OK  = 3;
    localparam int S_BAD = 4;

    localparam logic [9:0] K285P   = 10'b1100000101;
    localparam logic [9:0] D56     = 10'b1010010110;
    localparam logic [9:0] D00     = 10'b1001110100;
    localparam logic [9:0] CG_ZERO = 10'h000;
    localparam logic [9:0] CG_ONES = 10'h3FF;

    logic              clk = 1'b0;
    logic              RESET;
    logic [10*N-1:0]   rx_code_group;
    logic [N-1:0]      lane_enable;
    logic [10*N-1:0]   rx_code_group_out;
    logic [N-1:0]      code_status;
    logic [N-1:0]      rx_even;
    logic [N-1:0]      cg_invalid;
    logic              all_sync;

    sincronizador_multicanal #(
        .NUM_LANES   (N),
        .ACQ_COMMAS  (ACQ),
        .GOOD_CGS    (GOOD),
        .LOSS_LEVELS (LOSSL),
        .COMMA_BOTH  (1'b1)
    ) dut (
        .clk               (clk),
        .RESET             (RESET),
        .rx_code_group     (rx_code_group),
        .lane_enable       (lane_enable),
        .rx_code_group_out (rx_code_group_out),
        .code_status       (code_status),
        .rx_even           (rx_even),
        .cg_invalid        (cg_invalid),
        .all_sync          (all_sync)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10*N-1:0] cg;
        logic [N-1:0]    cs;
        logic [N-1:0]    ev;
        logic [N-1:0]    inv;
        logic            as;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int m_st[N];
    int m_cc[N];
    int m_bl[N];
    int m_gc[N];
    bit m_ev[N];

    function automatic bit ref_valid(input logic [9:0] g);
        case (g)
            10'b1001110100, 10'b0110001011, 10'b0111010100, 10'b1000101011,
            10'b1011010100, 10'b0100101011, 10'b1100011011, 10'b1100010100,
            10'b1101010100, 10'b0010101011, 10'b1010011011, 10'b1010010100,
            10'b0110011011, 10'b0110010100, 10'b1110001011, 10'b0001110100,
            10'b1110010100, 10'b0001101011, 10'b1001011011, 10'b1001010100,
            10'b1010010110, 10'b1001000101, 10'b0011111010, 10'b1100000101,
            10'b1101101000, 10'b0010010111, 10'b1011101000, 10'b0100010111:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic [10*N-1:0] rep(input logic [9:0] g);
        return {N{g}};
    endfunction

    // Reference model: advance every lane by one group and queue the outcome
    task automatic model_push(input logic [10*N-1:0] cg, input logic [N-1:0] en, input logic rst);
        exp_t       e;
        logic [9:0] g;
        bit         v, c, d, se, bad, any_en, all_ok;
        e      = '0;
        any_en = 1'b0;
        all_ok = 1'b1;
        for (int l = 0; l < N; l++) begin
            if (rst || !en[l]) begin
                m_st[l] = S_LOS;
                m_cc[l] = 0;
                m_bl[l] = 0;
                m_gc[l] = 0;
                m_ev[l] = 1'b0;
            end else begin
                g   = cg[10*l +: 10];
                v   = ref_valid(g);
                c   = (g[9:3] == 7'b1100000) || (g[9:3] == 7'b0011111);
                d   = (g == 10'b1010010110) || (g == 10'b1001000101);
                se  = (m_st[l] == S_LOS && c) ? 1'b1 : !m_ev[l];
                bad = !v || (c && !se);
                case (m_st[l])
                    S_LOS: if (c) begin m_st[l] = S_CD; m_cc[l] = 1; end
                    S_CD: begin
                        if (d && m_cc[l] == ACQ) m_st[l] = S_OK;
                        else if (d)              m_st[l] = S_ACQ;
                        else                     m_st[l] = S_LOS;
                    end
                    S_ACQ: begin
                        if (bad) m_st[l] = S_LOS;
                        else if (c) begin
                            m_st[l] = S_CD;
                            if (m_cc[l] < ACQ) m_cc[l]++;
                        end
                    end
                    S_OK: if (bad) begin m_st[l] = S_BAD; m_bl[l] = 1; m_gc[l] = 0; end
                    S_BAD: begin
                        if (bad) begin
                            if (m_bl[l] == LOSSL) m_st[l] = S_LOS;
                            else begin m_bl[l]++; m_gc[l] = 0; end
                        end else begin
                            m_gc[l]++;
                            if (m_gc[l] == GOOD) begin
                                m_gc[l] = 0;
                                m_bl[l]--;
                                if (m_bl[l] == 0) m_st[l] = S_OK;
                            end
                        end
                    end
                    default: m_st[l] = S_LOS;
                endcase
                m_ev[l]            = se;
                e.cg[10*l +: 10]   = g;
                e.cs[l]            = (m_st[l] >= S_OK);
                e.ev[l]            = se;
                e.inv[l]           = bad;
                any_en             = 1'b1;
                if (!e.cs[l]) all_ok = 1'b0;
            end
        end
        e.as = !rst && any_en && all_ok;
        sb_q.push_back(e);
    endtask

    // Drive one group per lane on the falling edge and record its expectation
    task automatic drive(input logic [10*N-1:0] cg, input logic [N-1:0] en, input logic rst);
        @(negedge clk);
        rx_code_group = cg;
        lane_enable   = en;
        RESET         = rst;
        model_push(cg, en, rst);
    endtask

    // Scoreboard: compare every output against the queued expectation
    always @(posedge clk) begin : sb_monitor
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checks++;
            if (rx_code_group_out !== e.cg) begin
                errors++;
                $display("FAIL sb_cg_out t=%0t got %h exp %h", $time, rx_code_group_out, e.cg);
            end
            checks++;
            if (code_status !== e.cs) begin
                errors++;
                $display("FAIL sb_code_status t=%0t got %b exp %b", $time, code_status, e.cs);
            end
            checks++;
            if (rx_even !== e.ev) begin
                errors++;
                $display("FAIL sb_rx_even t=%0t got %b exp %b", $time, rx_even, e.ev);
            end
            checks++;
            if (cg_invalid !== e.inv) begin
                errors++;
                $display("FAIL sb_cg_invalid t=%0t got %b exp %b", $time, cg_invalid, e.inv);
            end
            checks++;
            if (all_sync !== e.as) begin
                errors++;
                $display("FAIL sb_all_sync t=%0t got %b exp %b", $time, all_sync, e.as);
            end
        end
    end

    task automatic test_reset();
        drive(rep(K285P), 4'hF, 1'b1);
        drive(rep(K285P), 4'hF, 1'b1);
        @(posedge clk); #2;
        checks++;
        if ({code_status, rx_even, cg_invalid, all_sync} !== 13'd0) begin
            errors++;
            $display("FAIL reset_status got %b exp 0", {code_status, rx_even, cg_invalid, all_sync});
        end
        checks++;
        if (rx_code_group_out !== 40'd0) begin
            errors++;
            $display("FAIL reset_cg_out got %h exp 0", rx_code_group_out);
        end
    endtask

    task automatic test_acquire();
        logic exp_ev, exp_cs;
        for (int j = 0; j < 6; j++) begin
            drive(rep((j % 2 == 0) ? K285P : D56), 4'hF, 1'b0);
            @(posedge clk); #2;
            exp_ev = (j % 2 == 0);
            exp_cs = (j == 5);
            checks++;
            if (rx_even[0] !== exp_ev) begin
                errors++;
                $display("FAIL acq_rx_even j=%0d got %b exp %b", j, rx_even[0], exp_ev);
            end
            checks++;
            if (code_status[0] !== exp_cs) begin
                errors++;
                $display("FAIL acq_code_status j=%0d got %b exp %b", j, code_status[0], exp_cs);
            end
        end
        checks++;
        if (all_sync !== 1'b1) begin
            errors++;
            $display("FAIL acq_all_sync got %b exp 1", all_sync);
        end
    endtask

    task automatic test_single_bad();
        drive(rep(CG_ZERO), 4'hF, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (cg_invalid[0] !== 1'b1 || code_status[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_bad got inv=%b cs=%b exp inv=1 cs=1", cg_invalid[0], code_status[0]);
        end
        for (int j = 0; j < 4; j++) begin
            drive(rep(D00), 4'hF, 1'b0);
            @(posedge clk); #2;
            checks++;
            if (cg_invalid[0] !== 1'b0 || code_status[0] !== 1'b1) begin
                errors++;
                $display("FAIL single_bad_recover j=%0d got inv=%b cs=%b exp inv=0 cs=1", j, cg_invalid[0], code_status[0]);
            end
        end
    endtask

    task automatic test_loss();
        logic exp_cs;
        for (int j = 0; j < 3; j++) begin
            drive(rep(CG_ONES), 4'hF, 1'b0);
            @(posedge clk); #2;
            checks++;
            if (code_status[0] !== 1'b1) begin
                errors++;
                $display("FAIL three_bad j=%0d got %b exp 1", j, code_status[0]);
            end
        end
        for (int j = 0; j < 3 * GOOD; j++) begin
            drive(rep(D00), 4'hF, 1'b0);
            @(posedge clk); #2;
            checks++;
            if (code_status[0] !== 1'b1) begin
                errors++;
                $display("FAIL bad_recover j=%0d got %b exp 1", j, code_status[0]);
            end
        end
        for (int j = 0; j < 4; j++) begin
            drive(rep(CG_ONES), 4'hF, 1'b0);
            @(posedge clk); #2;
            exp_cs = (j != 3);
            checks++;
            if (code_status[0] !== exp_cs) begin
                errors++;
                $display("FAIL four_bad j=%0d got %b exp %b", j, code_status[0], exp_cs);
            end
        end
    endtask

    task automatic test_odd_comma();
        drive(rep(K285P), 4'hF, 1'b0);
        drive(rep(D56), 4'hF, 1'b0);
        drive(rep(D00), 4'hF, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (cg_invalid[0] !== 1'b0) begin
            errors++;
            $display("FAIL odd_comma_pre got %b exp 0", cg_invalid[0]);
        end
        drive(rep(K285P), 4'hF, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (cg_invalid[0] !== 1'b1 || code_status[0] !== 1'b0) begin
            errors++;
            $display("FAIL odd_comma got inv=%b cs=%b exp inv=1 cs=0", cg_invalid[0], code_status[0]);
        end
        drive(rep(D56), 4'hF, 1'b0);
    endtask

    task automatic test_reset_mid_sync();
        logic exp_cs;
        for (int j = 0; j < 6; j++) drive(rep((j % 2 == 0) ? K285P : D56), 4'hF, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (code_status !== 4'hF) begin
            errors++;
            $display("FAIL resync_pre got %b exp 1111", code_status);
        end
        drive(rep(K285P), 4'hF, 1'b1);
        @(posedge clk); #2;
        checks++;
        if ({rx_code_group_out, code_status, rx_even, cg_invalid, all_sync} !== 53'd0) begin
            errors++;
            $display("FAIL mid_reset got %h exp 0", {rx_code_group_out, code_status, rx_even, cg_invalid, all_sync});
        end
        for (int j = 0; j < 6; j++) begin
            drive(rep((j % 2 == 0) ? K285P : D56), 4'hF, 1'b0);
            @(posedge clk); #2;
            exp_cs = (j == 5);
            checks++;
            if (code_status[0] !== exp_cs) begin
                errors++;
                $display("FAIL reacquire j=%0d got %b exp %b", j, code_status[0], exp_cs);
            end
        end
    endtask

    task automatic test_lane_enable();
        logic [9:0] g;
        logic       exp_as;
        drive(rep(K285P), 4'hF, 1'b1);
        for (int j = 0; j < 6; j++) begin
            g = (j % 2 == 0) ? K285P : D56;
            drive({CG_ONES, g, g, g}, 4'b0111, 1'b0);
        end
        @(posedge clk); #2;
        checks++;
        if (all_sync !== 1'b1 || code_status !== 4'b0111) begin
            errors++;
            $display("FAIL lane3_off got as=%b cs=%b exp as=1 cs=0111", all_sync, code_status);
        end
        for (int j = 0; j < 6; j++) begin
            drive(rep((j % 2 == 0) ? K285P : D56), 4'hF, 1'b0);
            @(posedge clk); #2;
            exp_as = (j == 5);
            checks++;
            if (all_sync !== exp_as) begin
                errors++;
                $display("FAIL lane3_on j=%0d got %b exp %b", j, all_sync, exp_as);
            end
        end
        drive(rep(D00), 4'h0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (all_sync !== 1'b0 || code_status !== 4'h0) begin
            errors++;
            $display("FAIL none_enabled got as=%b cs=%b exp 0", all_sync, code_status);
        end
    endtask

    initial begin
        RESET         = 1'b1;
        lane_enable   = '0;
        rx_code_group = '0;
        test_reset();
        test_acquire();
        test_single_bad();
        test_loss();
        test_odd_comma();
        test_reset_mid_sync();
        test_lane_enable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

endmodule
